// File: rtl/la_capture_core.sv
// Logic-analyser capture engine: value/mask trigger channels, Nth-hit trigger,
// programmable pre-trigger depth, circular sample buffer and handshake readout.
module la_capture_core #(
    parameter int DATA_W   = 52,
    parameter int DEPTH    = 1024,
    parameter int NUM_TRIG = 5,
    parameter int TRIG_W   = 16,
    parameter int CNT_W    = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [DATA_W-1:0]            data_i,
    input  logic [NUM_TRIG*TRIG_W-1:0]   trig_i,
    input  logic [NUM_TRIG*TRIG_W-1:0]   trig_val_i,
    input  logic [NUM_TRIG*TRIG_W-1:0]   trig_mask_i,
    input  logic                         trig_mode_i,
    input  logic [CNT_W-1:0]             trig_count_i,
    input  logic [$clog2(DEPTH)-1:0]     pre_depth_i,
    input  logic                         sample_en_i,
    input  logic                         arm_i,
    input  logic                         abort_i,
    input  logic                         rd_start_i,
    output logic [DATA_W-1:0]            rd_data_o,
    output logic                         rd_valid_o,
    input  logic                         rd_ready_i,
    output logic                         rd_last_o,
    output logic [2:0]                   state_o,
    output logic                         triggered_o,
    output logic [$clog2(DEPTH)-1:0]     trig_pos_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = NUM_TRIG * TRIG_W;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_ARMED = 3'd2,
        S_POST  = 3'd3,
        S_DONE  = 3'd4,
        S_READ  = 3'd5
    } state_t;

    state_t              state_reg, state_next;
    logic [DATA_W-1:0]   data_reg;
    logic [TW-1:0]       trig_reg;
    logic                en_reg;
    logic [TW-1:0]       cfg_val_reg, cfg_mask_reg;
    logic                cfg_mode_reg;
    logic [CNT_W-1:0]    cfg_count_reg;
    logic [AW-1:0]       cfg_pre_reg;
    logic [AW-1:0]       wr_ptr_reg, rd_ptr_reg, beat_reg, cnt_reg, trig_pos_reg;
    logic [CNT_W-1:0]    hit_cnt_reg;
    logic                rd_valid_reg, triggered_reg;
    logic [DATA_W-1:0]   rd_q_reg;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic [NUM_TRIG-1:0] chan_hit;
    logic                hit, fire, arm_ok, rd_go, xfer, last_beat;
    logic                wr_en, rd_en;
    logic [AW-1:0]       rd_addr;

    generate
        for (genvar gi = 0; gi < NUM_TRIG; gi++) begin : g_chan
            assign chan_hit[gi] = ((trig_reg[gi*TRIG_W +: TRIG_W] ^ cfg_val_reg[gi*TRIG_W +: TRIG_W])
                                   & cfg_mask_reg[gi*TRIG_W +: TRIG_W]) == '0;
        end
    endgenerate

    assign hit       = cfg_mode_reg ? (|chan_hit) : (&chan_hit);
    assign fire      = (state_reg == S_ARMED) && en_reg && hit && (hit_cnt_reg == cfg_count_reg);
    assign arm_ok    = arm_i && !abort_i && (state_reg == S_IDLE || state_reg == S_DONE);
    // An arm arriving together with rd_start in DONE restarts the capture instead.
    assign rd_go     = rd_start_i && !abort_i && !arm_i && (state_reg == S_DONE);
    assign last_beat = (beat_reg == AW'(DEPTH - 1));
    assign xfer      = (state_reg == S_READ) && rd_valid_reg && rd_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_reg <= S_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (abort_i) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (arm_ok)     state_next = (pre_depth_i == '0) ? S_ARMED : S_FILL;
                    else if (rd_go) state_next = S_READ;
                end
                S_FILL:  if (en_reg && cnt_reg == '0) state_next = S_ARMED;
                S_ARMED: if (fire) state_next = (cfg_pre_reg == AW'(DEPTH - 1)) ? S_DONE : S_POST;
                S_POST:  if (en_reg && cnt_reg == AW'(1)) state_next = S_DONE;
                S_READ:  if (xfer && last_beat) state_next = S_DONE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        rd_addr = rd_ptr_reg + AW'(1);
        case (state_reg)
            S_FILL, S_ARMED, S_POST: wr_en = en_reg;
            S_DONE: begin
                rd_en   = rd_go;
                rd_addr = wr_ptr_reg;
            end
            S_READ:  rd_en = xfer && !last_beat;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr_reg] <= data_reg;
    end

    // Read register only advances on a transfer, so data holds during stalls.
    always_ff @(posedge clk_i) begin
        if (rst_i)      rd_q_reg <= '0;
        else if (rd_en) rd_q_reg <= mem[rd_addr];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_reg      <= '0;
            trig_reg      <= '0;
            en_reg        <= 1'b0;
            cfg_val_reg   <= '0;
            cfg_mask_reg  <= '0;
            cfg_mode_reg  <= 1'b0;
            cfg_count_reg <= '0;
            cfg_pre_reg   <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            beat_reg      <= '0;
            cnt_reg       <= '0;
            hit_cnt_reg   <= '0;
            rd_valid_reg  <= 1'b0;
            triggered_reg <= 1'b0;
            trig_pos_reg  <= '0;
        end else begin
            data_reg <= data_i;
            trig_reg <= trig_i;
            en_reg   <= sample_en_i;

            if (wr_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);

            case (state_reg)
                S_FILL: if (en_reg) cnt_reg <= cnt_reg - AW'(1);
                S_ARMED: begin
                    if (fire) begin
                        triggered_reg <= 1'b1;
                        trig_pos_reg  <= cfg_pre_reg;
                        cnt_reg       <= ~cfg_pre_reg;  // DEPTH-1-pre post-trigger writes
                    end else if (en_reg && hit && hit_cnt_reg != '1) begin
                        hit_cnt_reg <= hit_cnt_reg + CNT_W'(1);
                    end
                end
                S_POST: if (en_reg) cnt_reg <= cnt_reg - AW'(1);
                default: ;
            endcase

            if (arm_ok) begin
                cfg_val_reg   <= trig_val_i;
                cfg_mask_reg  <= trig_mask_i;
                cfg_mode_reg  <= trig_mode_i;
                cfg_count_reg <= trig_count_i;
                cfg_pre_reg   <= pre_depth_i;
                wr_ptr_reg    <= '0;
                hit_cnt_reg   <= '0;
                cnt_reg       <= pre_depth_i - AW'(1);
                triggered_reg <= 1'b0;
                trig_pos_reg  <= '0;
            end

            if (rd_go) begin
                rd_ptr_reg   <= wr_ptr_reg;
                beat_reg     <= '0;
                rd_valid_reg <= 1'b1;
            end else if (xfer) begin
                if (last_beat) begin
                    rd_valid_reg <= 1'b0;
                end else begin
                    rd_ptr_reg <= rd_ptr_reg + AW'(1);
                    beat_reg   <= beat_reg + AW'(1);
                end
            end

            if (abort_i) begin
                rd_valid_reg  <= 1'b0;
                triggered_reg <= 1'b0;
                trig_pos_reg  <= '0;
            end
        end
    end

    assign rd_data_o   = rd_q_reg;
    assign rd_valid_o  = rd_valid_reg;
    assign rd_last_o   = rd_valid_reg && last_beat;
    assign state_o     = state_reg;
    assign triggered_o = triggered_reg;
    assign trig_pos_o  = trig_pos_reg;
endmodule

// File: tb/tb_la_capture_core.sv
// Directed bench for la_capture_core at DEPTH=16: trigger modes, Nth hit,
// pre-trigger depths, stalled/repeated readout, abort, qualifier gaps and reset.
module tb_la_capture_core;
    localparam int DATA_W   = 52;
    localparam int DEPTH    = 16;
    localparam int NUM_TRIG = 5;
    localparam int TRIG_W   = 16;
    localparam int CNT_W    = 16;
    localparam int AW       = 4;
    localparam int TW       = NUM_TRIG * TRIG_W;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic [DATA_W-1:0] data_i = '0;
    logic [TW-1:0]     trig_i = '0, trig_val_i = '0, trig_mask_i = '0;
    logic              trig_mode_i = 1'b0;
    logic [CNT_W-1:0]  trig_count_i = '0;
    logic [AW-1:0]     pre_depth_i = '0;
    logic              sample_en_i = 1'b1, arm_i = 1'b0, abort_i = 1'b0, rd_start_i = 1'b0;
    logic [DATA_W-1:0] rd_data_o;
    logic              rd_valid_o, rd_ready_i = 1'b0, rd_last_o, triggered_o;
    logic [2:0]        state_o;
    logic [AW-1:0]     trig_pos_o;

    int vectors = 0;
    int miscompares = 0;
    int dcnt = 0;
    logic [63:0] hit_set = '0;
    logic [63:0] en_off = '0;
    logic [DATA_W-1:0] exp_beats [DEPTH];

    always #5 clk = ~clk;

    la_capture_core #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_TRIG(NUM_TRIG), .TRIG_W(TRIG_W), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .trig_i(trig_i),
        .trig_val_i(trig_val_i), .trig_mask_i(trig_mask_i), .trig_mode_i(trig_mode_i),
        .trig_count_i(trig_count_i), .pre_depth_i(pre_depth_i), .sample_en_i(sample_en_i),
        .arm_i(arm_i), .abort_i(abort_i), .rd_start_i(rd_start_i),
        .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
        .rd_last_o(rd_last_o), .state_o(state_o), .triggered_o(triggered_o),
        .trig_pos_o(trig_pos_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: data_i is the free-running counter, channel 0 matches 0x00A5 on listed counts.
    task automatic cycle();
        data_i = DATA_W'(dcnt);
        for (int k = 0; k < NUM_TRIG; k++) begin
            if (k == 0)
                trig_i[k*TRIG_W +: TRIG_W] = (dcnt < 64 && hit_set[dcnt]) ? 16'h00A5 : 16'h0000;
            else
                trig_i[k*TRIG_W +: TRIG_W] = TRIG_W'(dcnt * 7 + k);
        end
        sample_en_i = !(dcnt < 64 && en_off[dcnt]);
        @(posedge clk);
        #1;
        dcnt++;
    endtask

    task automatic set_cfg(input logic mode, input logic [CNT_W-1:0] count, input logic [AW-1:0] pre);
        trig_val_i   = '0;
        trig_mask_i  = '0;
        trig_val_i[TRIG_W-1:0]  = 16'h00A5;
        trig_mask_i[TRIG_W-1:0] = 16'hFFFF;
        trig_mode_i  = mode;
        trig_count_i = count;
        pre_depth_i  = pre;
    endtask

    task automatic start_capture();
        dcnt  = 0;
        arm_i = 1'b1;
        cycle();
        arm_i = 1'b0;
    endtask

    task automatic run_until(input string tag, input logic [2:0] st);
        for (int c = 0; c < 200 && state_o !== st; c++) cycle();
        chk(tag, state_o, st);
    endtask

    task automatic read_burst(input string tag, input logic [15:0] ready_pat);
        int beats = 0;
        logic stalled = 1'b0;
        logic [DATA_W-1:0] held = '0;
        logic held_last = 1'b0;
        rd_start_i = 1'b1;
        cycle();
        rd_start_i = 1'b0;
        chk({tag, "_valid_lat"}, rd_valid_o, 1'b1);
        for (int c = 0; c < 200 && beats < DEPTH; c++) begin
            if (rd_valid_o) begin
                if (stalled) begin
                    chk({tag, "_hold_data"}, rd_data_o, held);
                    chk({tag, "_hold_last"}, rd_last_o, held_last);
                end
                rd_ready_i = ready_pat[c % 16];
                if (rd_ready_i) begin
                    chk($sformatf("%s_beat%0d", tag, beats), rd_data_o, exp_beats[beats]);
                    chk($sformatf("%s_last%0d", tag, beats), rd_last_o, (beats == DEPTH - 1));
                    beats++;
                    stalled = 1'b0;
                end else begin
                    stalled   = 1'b1;
                    held      = rd_data_o;
                    held_last = rd_last_o;
                end
            end
            cycle();
        end
        rd_ready_i = 1'b0;
        chk({tag, "_beats"}, beats, DEPTH);
        chk({tag, "_end_state"}, state_o, 3'd4);
        chk({tag, "_end_valid"}, rd_valid_o, 1'b0);
    endtask

    initial begin
        // Reset state
        cycle();
        cycle();
        chk("rst_state", state_o, 3'd0);
        chk("rst_valid", rd_valid_o, 1'b0);
        chk("rst_last", rd_last_o, 1'b0);
        chk("rst_trig", triggered_o, 1'b0);
        chk("rst_pos", trig_pos_o, 4'd0);
        chk("rst_data", rd_data_o, 52'd0);
        rst_i = 1'b0;
        cycle();

        // AND mode, first hit at 20, pre-depth 4: window is 16..31
        set_cfg(1'b0, 16'd0, 4'd4);
        hit_set = 64'd1 << 20;
        start_capture();
        chk("t1_fill", state_o, 3'd1);
        run_until("t1_done", 3'd4);
        chk("t1_done_time", dcnt, 33);
        chk("t1_trig", triggered_o, 1'b1);
        chk("t1_pos", trig_pos_o, 4'd4);
        for (int b = 0; b < DEPTH; b++) exp_beats[b] = DATA_W'(16 + b);
        read_burst("t1", 16'hFFFF);

        // Third hit fires; hit during FILL ignored; config changes after arm ignored
        set_cfg(1'b0, 16'd2, 4'd4);
        hit_set = (64'd1 << 2) | (64'd1 << 10) | (64'd1 << 14) | (64'd1 << 20);
        start_capture();
        pre_depth_i  = 4'd9;
        trig_count_i = 16'd7;
        run_until("t2_done", 3'd4);
        chk("t2_done_time", dcnt, 33);
        chk("t2_pos", trig_pos_o, 4'd4);
        read_burst("t2s", 16'b1001_1010_0110_1101);
        read_burst("t2r", 16'hFFFF);

        // OR mode with always-hit channels, pre-depth 0: goes straight to ARMED
        set_cfg(1'b1, 16'd0, 4'd0);
        hit_set = '0;
        start_capture();
        chk("t3_armed", state_o, 3'd2);
        run_until("t3_done", 3'd4);
        chk("t3_done_time", dcnt, 17);
        chk("t3_trig", triggered_o, 1'b1);
        chk("t3_pos", trig_pos_o, 4'd0);
        for (int b = 0; b < DEPTH; b++) exp_beats[b] = DATA_W'(b);
        read_burst("t3", 16'b1011_0111_1101_1110);

        // Qualifier gap 17..19 and an arm during ARMED
        set_cfg(1'b0, 16'd0, 4'd4);
        hit_set = 64'd1 << 20;
        en_off  = (64'd1 << 17) | (64'd1 << 18) | (64'd1 << 19);
        start_capture();
        while (dcnt < 10) cycle();
        arm_i = 1'b1;
        cycle();
        arm_i = 1'b0;
        chk("t4_arm_ignored", state_o, 3'd2);
        run_until("t4_done", 3'd4);
        chk("t4_done_time", dcnt, 33);
        en_off = '0;
        exp_beats[0] = 52'd13;
        exp_beats[1] = 52'd14;
        exp_beats[2] = 52'd15;
        exp_beats[3] = 52'd16;
        for (int b = 4; b < DEPTH; b++) exp_beats[b] = DATA_W'(16 + b);
        read_burst("t4", 16'hFFFF);

        // Abort together with arm while in POST
        start_capture();
        run_until("t5_post", 3'd3);
        chk("t5_trig_post", triggered_o, 1'b1);
        abort_i = 1'b1;
        arm_i   = 1'b1;
        cycle();
        abort_i = 1'b0;
        arm_i   = 1'b0;
        chk("t5_abort_state", state_o, 3'd0);
        chk("t5_abort_trig", triggered_o, 1'b0);
        chk("t5_abort_pos", trig_pos_o, 4'd0);
        cycle();
        chk("t5_stay_idle", state_o, 3'd0);

        // Pre-depth 15: trigger is the final write, last beat
        set_cfg(1'b1, 16'd0, 4'd15);
        hit_set = '0;
        start_capture();
        run_until("t6_done", 3'd4);
        chk("t6_done_time", dcnt, 17);
        chk("t6_pos", trig_pos_o, 4'd15);
        for (int b = 0; b < DEPTH; b++) exp_beats[b] = DATA_W'(b);
        read_burst("t6", 16'hFFFF);

        // Reset in the middle of a readout
        rd_start_i = 1'b1;
        cycle();
        rd_start_i = 1'b0;
        rd_ready_i = 1'b1;
        cycle();
        cycle();
        chk("t7_mid_read", state_o, 3'd5);
        rst_i = 1'b1;
        cycle();
        rst_i      = 1'b0;
        rd_ready_i = 1'b0;
        chk("t7_rst_valid", rd_valid_o, 1'b0);
        chk("t7_rst_state", state_o, 3'd0);
        chk("t7_rst_trig", triggered_o, 1'b0);
        chk("t7_rst_last", rd_last_o, 1'b0);
        cycle();
        chk("t7_stay_idle", state_o, 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
